// File: rtl/addru_pipe_redundant_pkg.sv
// Shared types and helpers for the redundant pipelined adder: the per-stage
// result record, the redundancy modes and the bitwise majority voter.
package addru_pkg;

  // Upper bound on SEG_W; seg_res_t carries a zero-padded segment.
  localparam int SEG_MAX = 16;

  localparam int REPL_NONE = 1;
  localparam int REPL_DMR  = 2;
  localparam int REPL_TMR  = 3;

  typedef struct packed {
    logic               carry;
    logic [SEG_MAX-1:0] s;
  } seg_res_t;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

endpackage

// File: rtl/addru_pipe_redundant_if.sv
// Stream bus of the redundant adder: operand input, result output, fault
// injection and error bookkeeping.
interface addru_pipe_redundant_if #(
  parameter int WIDTH     = 8,
  parameter int ERR_CNT_W = 8
);
  // Handshake: a beat moves on a rising edge where valid && ready. The producer
  // holds valid and its data stable until that edge; ready may depend on the
  // consumer's state but never on valid of the same side.
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 inj_en;
  logic [WIDTH-1:0]     inj_mask;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH:0]       sum;
  logic                 out_err;
  logic                 out_fixed;
  logic                 err_sticky;
  logic [ERR_CNT_W-1:0] err_count;
  logic                 err_clr;

  modport master (
    output in_valid, a, b, inj_en, inj_mask, out_ready, err_clr,
    input  in_ready, out_valid, sum, out_err, out_fixed, err_sticky, err_count
  );

  modport slave (
    input  in_valid, a, b, inj_en, inj_mask, out_ready, err_clr,
    output in_ready, out_valid, sum, out_err, out_fixed, err_sticky, err_count
  );
endinterface

// File: rtl/addru_pipe_redundant_seg.sv
// One pipeline stage's replicated segment adders and the voter/comparator.
// Replica 0 takes the fault-injection mask; REPL is 1, 2 or 3.
module addru_seg_vote
  import addru_pkg::*;
#(
  parameter int SEG_W = 2,
  parameter int REPL  = 3
) (
  input  logic [SEG_W-1:0] a,
  input  logic [SEG_W-1:0] b,
  input  logic [SEG_W-1:0] mask,
  input  logic             cin,
  output seg_res_t         res,
  output logic             err
);

  logic [SEG_W:0] rep [REPL];
  logic [SEG_W:0] voted;

  always_comb begin
    for (int r = 0; r < REPL; r++) begin
      rep[r] = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, cin};
    end
    rep[0] = rep[0] ^ {1'b0, mask};
  end

  if (REPL == REPL_TMR) begin : g_tmr
    always_comb begin
      voted = '0;
      for (int i = 0; i <= SEG_W; i++) begin
        voted[i] = maj3(rep[0][i], rep[1][i], rep[2][i]);
      end
    end
    assign err = (rep[0] != rep[1]) || (rep[1] != rep[2]);
  end else if (REPL == REPL_DMR) begin : g_dmr
    // Replica 1 never sees the injection mask, so it is the one forwarded.
    assign voted = rep[1];
    assign err   = (rep[0] != rep[1]);
  end else begin : g_plain
    assign voted = rep[0];
    assign err   = 1'b0;
  end

  always_comb begin
    res       = '0;
    res.carry = voted[SEG_W];
    res.s     = SEG_MAX'(voted[SEG_W-1:0]);
  end

endmodule

// File: rtl/addru_pipe_redundant.sv
// Pipelined unsigned adder, SEG_W bits per stage, with replicated segments,
// per-result error tracking, a sticky error flag and a saturating error counter.
module addru_pipe_redundant
  import addru_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SEG_W     = 2,
  parameter int REPL      = 3,
  parameter int ERR_CNT_W = 8
) (
  input logic                   clk,
  input logic                   rst,
  addru_pipe_redundant_if.slave bus
);

  localparam int STAGES = WIDTH / SEG_W;

  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  logic [WIDTH-1:0] a_r [STAGES], b_r [STAGES], m_r [STAGES], s_r [STAGES];
  logic             v_r [STAGES], c_r [STAGES], e_r [STAGES];

  logic [WIDTH-1:0] a_in [STAGES], b_in [STAGES], m_in [STAGES], s_in [STAGES];
  logic [WIDTH-1:0] s_nxt [STAGES];
  logic             v_in [STAGES], c_in [STAGES], e_in [STAGES];
  seg_res_t         res [STAGES];
  logic             seg_err [STAGES];

  // Stage 0 reads the bus directly; later stages read the previous register.
  always_comb begin
    a_in[0] = bus.a;
    b_in[0] = bus.b;
    m_in[0] = bus.inj_en ? bus.inj_mask : '0;
    s_in[0] = '0;
    c_in[0] = 1'b0;
    e_in[0] = 1'b0;
    v_in[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_r[k-1];
      b_in[k] = b_r[k-1];
      m_in[k] = m_r[k-1];
      s_in[k] = s_r[k-1];
      c_in[k] = c_r[k-1];
      e_in[k] = e_r[k-1];
      v_in[k] = v_r[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    addru_seg_vote #(
      .SEG_W (SEG_W),
      .REPL  (REPL)
    ) u_seg (
      .a    (a_in[k][k*SEG_W +: SEG_W]),
      .b    (b_in[k][k*SEG_W +: SEG_W]),
      .mask (m_in[k][k*SEG_W +: SEG_W]),
      .cin  (c_in[k]),
      .res  (res[k]),
      .err  (seg_err[k])
    );
  end

  // Sum bits above the current segment are still zero, so OR merges it in.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      s_nxt[k] = s_in[k] | (WIDTH'(res[k].s) << (k * SEG_W));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        a_r[k] <= '0;
        b_r[k] <= '0;
        m_r[k] <= '0;
        s_r[k] <= '0;
        c_r[k] <= 1'b0;
        e_r[k] <= 1'b0;
      end
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= v_in[k];
        a_r[k] <= a_in[k];
        b_r[k] <= b_in[k];
        m_r[k] <= m_in[k];
        s_r[k] <= s_nxt[k];
        c_r[k] <= res[k].carry;
        e_r[k] <= v_in[k] & (e_in[k] | seg_err[k]);
      end
    end
  end

  assign bus.out_valid = v_r[STAGES-1];
  assign bus.sum       = {c_r[STAGES-1], s_r[STAGES-1]};
  assign bus.out_err   = e_r[STAGES-1];
  assign bus.out_fixed = e_r[STAGES-1] && (REPL == REPL_TMR);

  logic                 xfer_err;
  logic                 sticky_r;
  logic [ERR_CNT_W-1:0] count_r;

  assign xfer_err = bus.out_valid && bus.out_ready && bus.out_err;

  always_ff @(posedge clk) begin
    if (rst || bus.err_clr) begin
      sticky_r <= 1'b0;
      count_r  <= '0;
    end else if (xfer_err) begin
      sticky_r <= 1'b1;
      if (count_r != '1) count_r <= count_r + 1'b1;
    end
  end

  assign bus.err_sticky = sticky_r;
  assign bus.err_count  = count_r;

endmodule

// File: tb/tb_addru_pipe_redundant.sv
// Bench for addru_pipe_redundant: TMR, DMR and a 2-bit-counter TMR instance share
// one stimulus stream and are checked against a scoreboard and counter model.
module tb_addru_pipe_redundant;

  localparam int STAGES = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0, inj_mask = '0;
  logic       inj_en = 1'b0, out_ready = 1'b1, err_clr = 1'b0;
  logic [8:0] cur_sum = '0;
  logic       cur_err = 1'b0;

  addru_pipe_redundant_if #(.WIDTH(8), .ERR_CNT_W(8)) if_t ();
  addru_pipe_redundant_if #(.WIDTH(8), .ERR_CNT_W(8)) if_d ();
  addru_pipe_redundant_if #(.WIDTH(8), .ERR_CNT_W(2)) if_s ();

  assign {if_t.in_valid, if_t.a, if_t.b, if_t.inj_en, if_t.inj_mask, if_t.out_ready, if_t.err_clr} =
         {in_valid, a, b, inj_en, inj_mask, out_ready, err_clr};
  assign {if_d.in_valid, if_d.a, if_d.b, if_d.inj_en, if_d.inj_mask, if_d.out_ready, if_d.err_clr} =
         {in_valid, a, b, inj_en, inj_mask, out_ready, err_clr};
  assign {if_s.in_valid, if_s.a, if_s.b, if_s.inj_en, if_s.inj_mask, if_s.out_ready, if_s.err_clr} =
         {in_valid, a, b, inj_en, inj_mask, out_ready, err_clr};

  addru_pipe_redundant #(.WIDTH(8), .SEG_W(2), .REPL(3), .ERR_CNT_W(8)) u_tmr (.clk(clk), .rst(rst), .bus(if_t));
  addru_pipe_redundant #(.WIDTH(8), .SEG_W(2), .REPL(2), .ERR_CNT_W(8)) u_dmr (.clk(clk), .rst(rst), .bus(if_d));
  addru_pipe_redundant #(.WIDTH(8), .SEG_W(2), .REPL(3), .ERR_CNT_W(2)) u_sat (.clk(clk), .rst(rst), .bus(if_s));

  // ---------------- checking helpers ----------------
  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [9:0] exp_q[$];   // {err, sum}
  int         cyc_q[$];
  logic       front_seen = 1'b0;
  logic       lat_chk    = 1'b0;
  int         cnt_t = 0, cnt_s = 0;
  logic       stk = 1'b0;

  // Evaluated mid-cycle: inputs and outputs are stable and describe the next edge.
  always @(negedge clk) begin
    logic [9:0] e;
    logic       xe;
    cyc++;
    if (!rst) begin
      chk("err_count_tmr", 16'(if_t.err_count), 16'(cnt_t));
      chk("err_count_dmr", 16'(if_d.err_count), 16'(cnt_t));
      chk("err_count_sat", 16'(if_s.err_count), 16'(cnt_s));
      chk("err_sticky_tmr", 16'(if_t.err_sticky), 16'(stk));
      chk("err_sticky_dmr", 16'(if_d.err_sticky), 16'(stk));
      chk("out_valid_dmr", 16'(if_d.out_valid), 16'(if_t.out_valid));
      chk("out_valid_sat", 16'(if_s.out_valid), 16'(if_t.out_valid));
      if (if_t.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", 16'(if_t.out_valid), 16'd0);
        end else begin
          e = exp_q[0];
          chk("sum_tmr", 16'(if_t.sum), 16'(e[8:0]));
          chk("sum_dmr", 16'(if_d.sum), 16'(e[8:0]));
          chk("sum_sat", 16'(if_s.sum), 16'(e[8:0]));
          chk("out_err_tmr", 16'(if_t.out_err), 16'(e[9]));
          chk("out_err_dmr", 16'(if_d.out_err), 16'(e[9]));
          chk("out_fixed_tmr", 16'(if_t.out_fixed), 16'(e[9]));
          chk("out_fixed_dmr", 16'(if_d.out_fixed), 16'd0);
          if (lat_chk && !front_seen) chk("latency", 16'(cyc - cyc_q[0]), 16'(STAGES));
          front_seen = 1'b1;
        end
      end
      if (!if_t.out_valid) chk("in_ready_idle", 16'(if_t.in_ready), 16'd1);
      else if (!out_ready) chk("in_ready_stall", 16'(if_t.in_ready), 16'd0);
    end
    if (rst) begin
      exp_q.delete();
      cyc_q.delete();
      front_seen = 1'b0;
      cnt_t = 0;
      cnt_s = 0;
      stk   = 1'b0;
    end else begin
      xe = 1'b0;
      if (if_t.out_valid && out_ready && exp_q.size() > 0) begin
        xe = exp_q[0][9];
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
        front_seen = 1'b0;
      end
      if (in_valid && if_t.in_ready) begin
        exp_q.push_back({cur_err, cur_sum});
        cyc_q.push_back(cyc);
      end
      if (err_clr) begin
        cnt_t = 0;
        cnt_s = 0;
        stk   = 1'b0;
      end else if (xe) begin
        cnt_t = (cnt_t == 255) ? 255 : cnt_t + 1;
        cnt_s = (cnt_s == 3) ? 3 : cnt_s + 1;
        stk   = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] aa, input logic [7:0] bb, input logic ie,
                      input logic [7:0] mm, input logic [8:0] es, input logic ee);
    logic ok;
    in_valid = 1'b1; a = aa; b = bb; inj_en = ie; inj_mask = mm;
    cur_sum = es; cur_err = ee;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (if_t.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 16'd0, 16'd1);
    tick();
    in_valid = 1'b0; inj_en = 1'b0;
    a = 8'($urandom_range(0, 255)); b = 8'($urandom_range(0, 255));
    inj_mask = 8'($urandom_range(0, 255));
  endtask

  task automatic send_rand(input logic ie);
    logic [7:0] aa, bb, mm;
    aa = 8'($urandom_range(0, 255));
    bb = 8'($urandom_range(0, 255));
    mm = 8'($urandom_range(1, 255));
    send(aa, bb, ie, mm, {1'b0, aa} + {1'b0, bb}, ie);
  endtask

  task automatic drain();
    for (int i = 0; i < 80; i++) begin
      if (exp_q.size() == 0) break;
      tick();
    end
    chk("drain_queue_empty", 16'(exp_q.size()), 16'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ie;
    logic [7:0] m;
    logic [8:0] s;
    logic       e;
  } vec_t;

  vec_t vt [8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    logic ok;
    vt[0] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 9'h1FE, 1'b0};
    vt[1] = '{8'h00, 8'h00, 1'b0, 8'h00, 9'h000, 1'b0};
    vt[2] = '{8'h80, 8'h80, 1'b0, 8'h00, 9'h100, 1'b0};
    vt[3] = '{8'h12, 8'h34, 1'b1, 8'h04, 9'h046, 1'b1};
    vt[4] = '{8'h55, 8'hAA, 1'b0, 8'h00, 9'h0FF, 1'b0};
    vt[5] = '{8'h01, 8'h7F, 1'b0, 8'h00, 9'h080, 1'b0};
    vt[6] = '{8'hAA, 8'h55, 1'b1, 8'hFF, 9'h0FF, 1'b1};
    vt[7] = '{8'h03, 8'h01, 1'b1, 8'h00, 9'h004, 1'b0};

    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_out_valid", 16'(if_t.out_valid), 16'd0);
    chk("rst_sum", 16'(if_t.sum), 16'd0);
    chk("rst_out_err", 16'(if_t.out_err), 16'd0);
    chk("rst_out_fixed", 16'(if_t.out_fixed), 16'd0);
    chk("rst_err_sticky", 16'(if_t.err_sticky), 16'd0);
    chk("rst_err_count", 16'(if_t.err_count), 16'd0);
    rst = 1'b0;
    chk("rst_in_ready", 16'(if_t.in_ready), 16'd1);

    // Single transfer, carry through every stage, exact latency
    lat_chk = 1'b1;
    send(8'hFF, 8'h01, 1'b0, 8'h00, 9'h100, 1'b0);
    drain();

    // Back-to-back table vectors
    for (int i = 0; i < 8; i++) send(vt[i].a, vt[i].b, vt[i].ie, vt[i].m, vt[i].s, vt[i].e);
    drain();

    // Stream of 6 with a 5-cycle output stall mid-stream
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_rand(1'b0);
      end
      begin
        repeat (5) tick();
        out_ready = 1'b0;
        repeat (5) tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Single injected fault after clearing the bookkeeping
    lat_chk = 1'b1;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    send(8'h12, 8'h34, 1'b1, 8'h04, 9'h046, 1'b1);
    drain();
    tick();
    chk("inj_err_count", 16'(if_t.err_count), 16'd1);
    chk("inj_err_sticky", 16'(if_t.err_sticky), 16'd1);

    // err_clr on the same edge as an erroneous output transfer
    send(8'h12, 8'h34, 1'b1, 8'h04, 9'h046, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (if_t.out_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    if (!ok) chk("clr_wait_timeout", 16'd0, 16'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("clr_priority_count", 16'(if_t.err_count), 16'd0);
    chk("clr_priority_sticky", 16'(if_t.err_sticky), 16'd0);
    drain();

    // Saturation of a 2-bit counter after 5 faults
    for (int i = 0; i < 5; i++) send_rand(1'b1);
    drain();
    tick();
    chk("sat_err_count", 16'(if_s.err_count), 16'd3);
    chk("wide_err_count", 16'(if_t.err_count), 16'd5);

    // Random mix with random backpressure
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_rand(1'($urandom_range(0, 1)));
      end
      begin
        repeat (30) begin
          out_ready = 1'($urandom_range(0, 1));
          tick();
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with 3 results in flight
    for (int i = 0; i < 3; i++) send_rand(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("post_reset_idle", 16'(if_t.out_valid), 16'd0);
    end
    chk("post_reset_count", 16'(if_t.err_count), 16'd0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
